// File: rtl/ascon_hash_pkg.sv
// Shared definitions for the Ascon hash sequencer: state encoding and load-length helpers.
package ascon_hash_pkg;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_CLR   = 4'd1;
    localparam logic [3:0] ST_LOAD  = 4'd2;
    localparam logic [3:0] ST_PAD   = 4'd3;
    localparam logic [3:0] ST_START = 4'd4;
    localparam logic [3:0] ST_WAIT  = 4'd5;
    localparam logic [3:0] ST_RREQ  = 4'd6;
    localparam logic [3:0] ST_RCAP  = 4'd7;
    localparam logic [3:0] ST_SEND  = 4'd8;
    localparam logic [3:0] ST_DONE  = 4'd9;

    typedef enum logic [3:0] {
        IDLE  = ST_IDLE,
        CLR   = ST_CLR,
        LOAD  = ST_LOAD,
        PAD   = ST_PAD,
        START = ST_START,
        WAIT  = ST_WAIT,
        RREQ  = ST_RREQ,
        RCAP  = ST_RCAP,
        SEND  = ST_SEND,
        DONE  = ST_DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The core always absorbs at least one full 64-bit block, so short messages are zero padded.
    function automatic int load_beats(input int y, input int l);
        return max3(y, l, 64) / 8;
    endfunction

endpackage

// File: rtl/soc_hash_sequencer_if.sv
// Host-side streams of the hash sequencer: message bytes in, digest bytes out.
interface soc_hash_sequencer_if;

    logic [7:0] s_data_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;

    modport slave (
        input  s_data_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_valid_o
    );

    modport master (
        output s_data_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_valid_o
    );

endinterface

// File: rtl/soc_hash_sequencer.sv
// Sequencer driving the byte-serial Ascon hash core: clear, load, pad, start, wait, read back.
// Defining HASH_SEQ_TIMEOUT_EN adds a WAIT watchdog that raises the sticky err_o flag.
module soc_hash_sequencer
    import ascon_hash_pkg::*;
#(
    parameter int Y          = 40,
    parameter int L          = 256,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                clk,
    input  logic                rst,
    soc_hash_sequencer_if.slave host,
    output logic                core_rst_no,
    output logic                reg_inputxSS,
    output logic [7:0]          messagexSO,
    output logic                reg_startxSS,
    output logic                hash_startxSO,
    input  logic                hash_readyxSI,
    output logic                reg_outxSS,
    input  logic [7:0]          hash_digestxSI,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int MSG_BEATS  = Y / 8;
    localparam int LOAD_BEATS = load_beats(Y, L);
    localparam int DIG_BEATS  = L / 8;

    localparam logic [7:0] MSG_LAST  = 8'(MSG_BEATS - 1);
    localparam logic [7:0] LOAD_LAST = 8'(LOAD_BEATS - 1);
    localparam logic [7:0] DIG_LAST  = 8'(DIG_BEATS - 1);
    localparam logic [7:0] CLR_LAST  = 8'(CLR_CYCLES - 1);
    localparam state_t     AFTER_MSG = (MSG_BEATS == LOAD_BEATS) ? START : PAD;

    state_t     state, state_nx;
    logic [7:0] beat_cnt, beat_cnt_nx;
    logic [7:0] dig_cnt, dig_cnt_nx;
    logic [7:0] clr_cnt, clr_cnt_nx;
    logic [7:0] m_data, m_data_nx;

`ifdef HASH_SEQ_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_cnt, wd_cnt_nx;
    logic            err_q, err_nx;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign host.m_data_o = m_data;
    assign busy_o        = (state != IDLE);

    always_comb begin
        // NOTE: every output and next value gets a default first so no path can infer a latch.
        state_nx           = state;
        beat_cnt_nx        = beat_cnt;
        dig_cnt_nx         = dig_cnt;
        clr_cnt_nx         = clr_cnt;
        m_data_nx          = m_data;
        host.s_ready_o     = 1'b0;
        host.m_valid_o     = 1'b0;
        reg_inputxSS       = 1'b0;
        messagexSO         = 8'h00;
        reg_startxSS       = 1'b0;
        hash_startxSO      = 1'b0;
        reg_outxSS         = 1'b0;
        done_o             = 1'b0;
`ifdef HASH_SEQ_TIMEOUT_EN
        wd_cnt_nx          = wd_cnt;
        err_nx             = err_q;
`endif
        unique case (state)
            IDLE: if (host.s_valid_i) begin
                // The pending byte stays on the bus; it is consumed once LOAD is reached.
                state_nx    = CLR;
                beat_cnt_nx = 8'h00;
                dig_cnt_nx  = 8'h00;
                clr_cnt_nx  = 8'h00;
`ifdef HASH_SEQ_TIMEOUT_EN
                err_nx      = 1'b0;
`endif
            end
            CLR: begin
                if (clr_cnt == CLR_LAST) state_nx = LOAD;
                else                     clr_cnt_nx = clr_cnt + 8'd1;
            end
            LOAD: begin
                host.s_ready_o = 1'b1;
                if (host.s_valid_i) begin
                    reg_inputxSS = 1'b1;
                    messagexSO   = host.s_data_i;
                    beat_cnt_nx  = beat_cnt + 8'd1;
                    if (beat_cnt == MSG_LAST) state_nx = AFTER_MSG;
                end
            end
            PAD: begin
                reg_inputxSS = 1'b1;
                beat_cnt_nx  = beat_cnt + 8'd1;
                if (beat_cnt == LOAD_LAST) state_nx = START;
            end
            START: begin
                reg_startxSS  = 1'b1;
                hash_startxSO = 1'b1;
                state_nx      = WAIT;
`ifdef HASH_SEQ_TIMEOUT_EN
                wd_cnt_nx     = '0;
`endif
            end
            WAIT: begin
                if (hash_readyxSI) state_nx = RREQ;
`ifdef HASH_SEQ_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wd_cnt_nx = wd_cnt + 1'b1;
                end
`endif
            end
            RREQ: begin
                reg_outxSS = 1'b1;
                state_nx   = RCAP;
            end
            RCAP: begin
                m_data_nx = hash_digestxSI;
                state_nx  = SEND;
            end
            SEND: begin
                host.m_valid_o = 1'b1;
                if (host.m_ready_i) begin
                    dig_cnt_nx = dig_cnt + 8'd1;
                    state_nx   = (dig_cnt == DIG_LAST) ? DONE : RREQ;
                end
            end
            DONE: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= 8'h00;
            dig_cnt     <= 8'h00;
            clr_cnt     <= 8'h00;
            m_data      <= 8'h00;
            core_rst_no <= 1'b0;
`ifdef HASH_SEQ_TIMEOUT_EN
            wd_cnt      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state       <= state_nx;
            beat_cnt    <= beat_cnt_nx;
            dig_cnt     <= dig_cnt_nx;
            clr_cnt     <= clr_cnt_nx;
            m_data      <= m_data_nx;
            // Registered so the core stays held in reset until the first clock after rst.
            core_rst_no <= (state_nx != CLR);
`ifdef HASH_SEQ_TIMEOUT_EN
            wd_cnt      <= wd_cnt_nx;
            err_q       <= err_nx;
`endif
        end
    end

endmodule

// File: tb/tb_soc_hash_sequencer.sv
// Randomized self-checking bench for soc_hash_sequencer with a behavioural Ascon core model.
// Define HASH_SEQ_TIMEOUT_EN to also exercise the WAIT watchdog (TIMEOUT=16).
module tb_soc_hash_sequencer;

    localparam int MSG_BEATS  = 5;
    localparam int LOAD_BEATS = 32;
    localparam int DIG_BEATS  = 32;
    localparam int CLR_CYCLES = 2;
    localparam int READY_DLY  = 100;
`ifdef HASH_SEQ_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 4096;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       core_rst_no, reg_inputxSS, reg_startxSS, hash_startxSO, reg_outxSS;
    logic       busy_o, done_o, err_o;
    logic [7:0] messagexSO;
    logic       hash_readyxSI  = 1'b0;
    logic [7:0] hash_digestxSI = 8'h00;

    always #5 clk = ~clk;

    soc_hash_sequencer_if host ();

    soc_hash_sequencer #(
        .Y(40), .L(256), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .host(host),
        .core_rst_no(core_rst_no), .reg_inputxSS(reg_inputxSS), .messagexSO(messagexSO),
        .reg_startxSS(reg_startxSS), .hash_startxSO(hash_startxSO), .hash_readyxSI(hash_readyxSI),
        .reg_outxSS(reg_outxSS), .hash_digestxSI(hash_digestxSI),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Job data and core/host models
    logic [7:0] msg [MSG_BEATS];
    logic [7:0] dig [DIG_BEATS];
    logic [7:0] beats_q [$];
    logic [7:0] rx_q [$];
    int  rout_by_idx [DIG_BEATS+1];
    int  rd_ptr = 0, ready_cd = 0, cyc = 0;
    int  clr_cyc, start_cnt, start_skew, rout_cnt, done_cnt, valid_cnt, err_hi;
    int  start_cyc, err_cyc;
    int  hold_idx = -1, hold_left = 0, hold_bad = 0;
    bit  never_ready = 1'b0, sink_rand = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hash_readyxSI  = 1'b0;
            rd_ptr         = 0;
            ready_cd       = 0;
            host.m_ready_i = 1'b0;
        end else begin
            if (!core_rst_no) begin
                clr_cyc++;
                hash_readyxSI = 1'b0;
                rd_ptr        = 0;
                ready_cd      = 0;
            end else begin
                if (reg_inputxSS) beats_q.push_back(messagexSO);
                if (reg_startxSS !== hash_startxSO) start_skew++;
                if (hash_startxSO) begin
                    start_cnt++;
                    start_cyc = cyc;
                    ready_cd  = READY_DLY;
                end else if (ready_cd > 0) begin
                    ready_cd--;
                    if (ready_cd == 0 && !never_ready) hash_readyxSI = 1'b1;
                end
                if (reg_outxSS) begin
                    rout_cnt++;
                    rout_by_idx[(rx_q.size() > DIG_BEATS) ? DIG_BEATS : rx_q.size()]++;
                    hash_digestxSI = dig[rd_ptr % DIG_BEATS];
                    rd_ptr++;
                end
            end
            if (done_o) done_cnt++;
            if (err_o) begin
                err_hi++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (host.m_valid_o) valid_cnt++;
            // Downstream sink: decide ready for the coming edge, then log the handshake it makes.
            if (host.m_valid_o && rx_q.size() == hold_idx && hold_left > 0) begin
                host.m_ready_i = 1'b0;
                hold_left--;
                if (host.m_data_o !== dig[hold_idx]) hold_bad++;
            end else begin
                host.m_ready_i = sink_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (host.m_valid_o && host.m_ready_i) rx_q.push_back(host.m_data_o);
        end
    end

    task automatic clear_mon();
        beats_q.delete();
        rx_q.delete();
        foreach (rout_by_idx[i]) rout_by_idx[i] = 0;
        clr_cyc = 0; start_cnt = 0; start_skew = 0; rout_cnt = 0; done_cnt = 0;
        valid_cnt = 0; err_hi = 0; start_cyc = -1; err_cyc = -1; hold_bad = 0;
    endtask

    task automatic rand_job();
        foreach (msg[i]) msg[i] = 8'($urandom);
        foreach (dig[i]) dig[i] = 8'($urandom);
    endtask

    task automatic send_msg(input string tag, input bit gaps);
        int guard;
        for (int i = 0; i < MSG_BEATS; i++) begin
            host.s_valid_i = 1'b1;
            host.s_data_i  = msg[i];
            guard = 0;
            @(negedge clk);
            while (!host.s_ready_o && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                check({tag, "_load_timeout"}, 64'(guard), 64'(0));
                break;
            end
            @(posedge clk);
            #1;
            if (gaps && i < MSG_BEATS - 1 && $urandom_range(0, 2) == 0) begin
                host.s_valid_i = 1'b0;
                host.s_data_i  = 8'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        host.s_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_job(input string tag);
        int errs = 0;
        check({tag, "_clr_cycles"}, 64'(clr_cyc), 64'(CLR_CYCLES));
        check({tag, "_load_beats"}, 64'(beats_q.size()), 64'(LOAD_BEATS));
        for (int i = 0; i < beats_q.size(); i++)
            if (beats_q[i] !== ((i < MSG_BEATS) ? msg[i] : 8'h00)) errs++;
        check({tag, "_beat_data_errs"}, 64'(errs), 64'(0));
        check({tag, "_start_pulses"}, 64'(start_cnt), 64'(1));
        check({tag, "_start_skew"}, 64'(start_skew), 64'(0));
        check({tag, "_digest_len"}, 64'(rx_q.size()), 64'(DIG_BEATS));
        errs = 0;
        for (int i = 0; i < rx_q.size() && i < DIG_BEATS; i++)
            if (rx_q[i] !== dig[i]) errs++;
        check({tag, "_digest_errs"}, 64'(errs), 64'(0));
        errs = 0;
        for (int i = 0; i < DIG_BEATS; i++) if (rout_by_idx[i] != 1) errs++;
        check({tag, "_rout_per_byte_errs"}, 64'(errs), 64'(0));
        check({tag, "_rout_total"}, 64'(rout_cnt), 64'(DIG_BEATS));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
        check({tag, "_err_high"}, 64'(err_hi), 64'(0));
        check({tag, "_idle_busy"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        host.s_valid_i = 1'b0;
        host.s_data_i  = 8'h00;
        clear_mon();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs",
              64'({core_rst_no, busy_o, done_o, err_o, host.s_ready_o, host.m_valid_o, reg_inputxSS,
                   reg_startxSS, hash_startxSO, reg_outxSS, host.m_data_o, messagexSO}), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_core_released", 64'(core_rst_no), 64'(1));
        check("rst_idle_busy", 64'(busy_o), 64'(0));

        // Job 1: bytes 01..05, digest 00..1F, byte 7 held off for 10 cycles
        foreach (msg[i]) msg[i] = 8'(i + 1);
        foreach (dig[i]) dig[i] = 8'(i);
        clear_mon();
        sink_rand = 1'b0;
        hold_idx  = 7;
        hold_left = 10;
        send_msg("job1", 1'b0);
        wait_done("job1");
        check_job("job1");
        check("job1_hold_consumed", 64'(hold_left), 64'(0));
        check("job1_hold_data_errs", 64'(hold_bad), 64'(0));
        hold_idx = -1;

        // Jobs 2-3: random data, input gaps, random downstream backpressure
        sink_rand = 1'b1;
        for (int j = 0; j < 2; j++) begin
            rand_job();
            clear_mon();
            send_msg("jobr", 1'b1);
            wait_done("jobr");
            check_job("jobr");
        end

        // Job 4: reset while byte 12 is waiting in SEND, then a clean job
        rand_job();
        clear_mon();
        hold_idx  = 12;
        hold_left = 100000;
        send_msg("jobrst", 1'b1);
        begin
            int n = 0;
            while (!(host.m_valid_o && rx_q.size() == 12) && n < 4000) begin
                @(negedge clk);
                n++;
            end
            check("jobrst_reached_byte12", 64'(host.m_valid_o && rx_q.size() == 12), 64'(1));
        end
        #2 rst = 1'b1;
        #1;
        check("jobrst_outputs",
              64'({busy_o, host.m_valid_o, core_rst_no, done_o, reg_outxSS}), 64'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        hold_idx  = -1;
        hold_left = 0;
        @(posedge clk);
        #1;
        rand_job();
        clear_mon();
        send_msg("jobpost", 1'b1);
        wait_done("jobpost");
        check_job("jobpost");

`ifdef HASH_SEQ_TIMEOUT_EN
        // Watchdog: core never signals ready
        rand_job();
        clear_mon();
        never_ready = 1'b1;
        send_msg("jobto", 1'b0);
        begin
            int n = 0;
            while (!err_o && n < 1000) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (3) @(negedge clk);
        check("jobto_err", 64'(err_o), 64'(1));
        check("jobto_err_latency", 64'(err_cyc - start_cyc), 64'(TIMEOUT + 1));
        check("jobto_no_valid", 64'(valid_cnt), 64'(0));
        check("jobto_no_done", 64'(done_cnt), 64'(0));
        check("jobto_no_rout", 64'(rout_cnt), 64'(0));
        check("jobto_idle_busy", 64'(busy_o), 64'(0));
        never_ready = 1'b0;
        rand_job();
        clear_mon();
        send_msg("jobafter", 1'b0);
        check("jobafter_err_cleared", 64'(err_o), 64'(0));
        wait_done("jobafter");
        check("jobafter_digest_len", 64'(rx_q.size()), 64'(DIG_BEATS));
        check("jobafter_done", 64'(done_cnt), 64'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
